song_sequencer: RTL and testbench
=================================

# song_sequencer

Playback controller that sequences the song reader. Turns user button pulses (play/pause, next, previous) and the reader's `song_done` into the `play` enable, the 2-bit song select and a one-cycle `reset_player` pulse. Sits between the debounced/one-pulsed button inputs and the song reader / note player chain. It also inserts a programmable silent gap between consecutive songs and supports loop-all playback.

## Interface

Parameters:

- `NUM_SONGS`, default 4: number of songs in the song ROM; legal range 1..4.
- `GAP_CYCLES`, default 12_500_000: length of the silent gap between songs, in clocks; legal range 1..2^24−1.

Ports:

- `clk` — input, 1 bit: system clock.
- `reset` — input, 1 bit: synchronous, active-high reset.
- `play_button` — input, 1 bit: single-cycle pulse; toggles play/pause.
- `next_button` — input, 1 bit: single-cycle pulse; skip to the next song.
- `prev_button` — input, 1 bit: single-cycle pulse; go back to the previous song.
- `loop_all` — input, 1 bit: level. When 1, the last song wraps to song 0 and keeps playing.
- `song_done` — input, 1 bit: single-cycle pulse from the song reader.
- `play` — output, 1 bit: enable to the song reader and note player.
- `song` — output, 2 bits: song select to the song reader. Registered.
- `reset_player` — output, 1 bit: one-cycle pulse that resets the song reader and note player. Registered.
- `in_gap` — output, 1 bit: high while in the GAP state.

## Operation

States:

- PAUSED: `play=0`.
- PLAYING: `play=1`.
- SWITCH: `play=0`; lasts exactly one cycle.
- GAP: `play=0`; `in_gap=1`.

Decoding:

- `play` and `in_gap` are decoded combinationally from the state register only.
- Song arithmetic is modulo `NUM_SONGS`:
  - next from song `NUM_SONGS−1` gives 0;
  - prev from song 0 gives `NUM_SONGS−1`.
- Every change of `song` is accompanied by `reset_player=1` in the same cycle the new value appears. At no other time is `reset_player` asserted.
- `next_button` and `prev_button` high together: both are ignored.

PAUSED:

- `play_button` → PLAYING; `song` is unchanged and there is no `reset_player`.
- Otherwise next/prev → update `song`, pulse `reset_player`, stay in PAUSED.
- `song_done` is ignored.

PLAYING. Priority is `song_done` > `play_button` > next/prev.

- `song_done` with `song==NUM_SONGS−1` and `loop_all==0` → `song` goes to 0, pulse `reset_player`, go to PAUSED.
- `song_done` otherwise → `song` advances by 1, pulse `reset_player`, load the gap counter with `GAP_CYCLES−1`, go to GAP.
- `play_button` → PAUSED; the song position is preserved because the reader is not reset.
- next/prev → update `song`, pulse `reset_player`, go to SWITCH.

SWITCH:

- Unconditionally → PLAYING.
- All inputs are ignored.
- Purpose: guarantees that `play` is low during the reader reset.

GAP. Priority is `play_button` > next/prev > count.

- `play_button` → PAUSED; the advanced `song` is kept.
- next/prev → update `song`, pulse `reset_player`, reload the counter with `GAP_CYCLES−1`, stay in GAP.
- Counter == 0 → PLAYING.
- Otherwise the counter decrements by 1.
- `song_done` is ignored.

Counter:

- 24-bit unsigned.
- Never decremented below 0.
- Holds its value outside GAP.

## Timing

- Reset values:
  - state PAUSED;
  - `song=0`;
  - `reset_player=0`;
  - `play=0`;
  - `in_gap=0`;
  - counter 0.
- Reset dominates every input in the same cycle.
- Reset mid-song drops `play` at the next edge. No `reset_player` pulse is generated by reset itself; the system reset covers the reader.
- Latency: an input sampled at edge N is reflected in the state, `play`, `song` and `reset_player` after edge N, i.e. 1 cycle.
- `reset_player` is high for exactly 1 cycle per song change.
- Gap length: `song_done` is sampled at edge N, so `play` is low for cycles N+1 .. N+`GAP_CYCLES`, and `play=1` again after edge N+`GAP_CYCLES`+1 − 1. That is, the GAP state occupies exactly `GAP_CYCLES` cycles.
- Skip while playing: `play` is low for exactly 1 cycle (SWITCH).
- Inputs are assumed to be single-cycle pulses. A level held high re-triggers every cycle; that is legal, and the behaviour follows the rules above per cycle.

## Test plan

Benches use `GAP_CYCLES=4` and `NUM_SONGS=4`.

- **Reset and start.** Reset, then `play_button` pulse.
  - `play=1` one cycle after the pulse.
  - `song=0`.
  - `reset_player` never asserted.
- **Auto-advance with gap.** In PLAYING on song 1, pulse `song_done`.
  - Next cycle: `song=2`, `reset_player=1` for 1 cycle, `in_gap=1`, `play=0`.
  - `play=0` for exactly 4 cycles, then `play=1`.
- **End of list.** On song 3 with `loop_all=0`, pulse `song_done` → `song=0`, one `reset_player` pulse, PAUSED (`play` stays 0).
  - Repeat with `loop_all=1` → `song=0`, GAP for 4 cycles, then PLAYING.
- **Wrap and skip.** In PAUSED on song 0, pulse `prev_button` → `song=3`, `reset_player` pulse, `play=0`.
  - In PLAYING on song 3, pulse `next_button` → `song=0`, `play` low for exactly 1 cycle, `reset_player` coincides with that low cycle.
- **Simultaneous events.**
  - In PLAYING, `song_done` + `play_button` in the same cycle → the `song_done` rule wins (GAP, song+1).
  - `next_button` + `prev_button` together → no change.
  - In GAP, `play_button` + `next_button` together → PAUSED, song unchanged from the gap value.
- **Reset mid-gap.** Assert `reset` during the GAP countdown at count 2 → next cycle PAUSED, `song=0`, `in_gap=0`, no `reset_player` pulse.

Source files
------------

// File: rtl/song_sequencer_if.sv
// rtl/song_sequencer_if.sv - button/event inputs and playback outputs of the song sequencer
//
// Signals:
//   play_button, next_button, prev_button - single-cycle user pulses
//   loop_all                               - level, wrap from last song to song 0 and keep playing
//   song_done                              - single-cycle pulse from the song reader
//   play                                   - enable to the song reader / note player
//   song[1:0]                              - song select to the song reader
//   reset_player                           - one-cycle reset pulse for the reader / player
//   in_gap                                 - high during the silent gap between songs
// Modports:
//   master - the button/reader side that drives the events
//   slave  - the sequencer itself
interface song_sequencer_if;
    logic       play_button;
    logic       next_button;
    logic       prev_button;
    logic       loop_all;
    logic       song_done;
    logic       play;
    logic [1:0] song;
    logic       reset_player;
    logic       in_gap;

    modport master (
        output play_button, next_button, prev_button, loop_all, song_done,
        input  play, song, reset_player, in_gap
    );

    modport slave (
        input  play_button, next_button, prev_button, loop_all, song_done,
        output play, song, reset_player, in_gap
    );
endinterface

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - playback controller sequencing the song reader
//
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - song_sequencer_if.slave: button pulses, loop_all, song_done in;
//           play, song (registered), reset_player (registered), in_gap out
// Parameters:
//   NUM_SONGS  - songs in the song ROM, 1..4
//   GAP_CYCLES - silent gap between consecutive songs in clocks, 1..2^24-1
module song_sequencer #(
    parameter int NUM_SONGS  = 4,
    parameter int GAP_CYCLES = 12_500_000
) (
    input  logic             clk,
    input  logic             reset,
    song_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        SWITCH  = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [1:0]  LAST_SONG = 2'(NUM_SONGS - 1);
    localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  song_q, song_d;
    logic        reset_player_q, reset_player_d;
    logic [23:0] count_q, count_d;

    logic        skip_fwd;
    logic        skip_back;
    logic        skip;
    logic [1:0]  next_song;
    logic [1:0]  prev_song;
    logic [1:0]  skip_song;

    // next and prev pressed together cancel each other out
    assign skip_fwd  = bus.next_button & ~bus.prev_button;
    assign skip_back = bus.prev_button & ~bus.next_button;
    assign skip      = skip_fwd | skip_back;

    assign next_song = (song_q == LAST_SONG) ? 2'd0 : song_q + 2'd1;
    assign prev_song = (song_q == 2'd0) ? LAST_SONG : song_q - 2'd1;
    assign skip_song = skip_fwd ? next_song : prev_song;

    // Every write to song_d also raises reset_player_d, so the reader reset
    // lands in exactly the cycle the new song select appears.
    always_comb begin
        state_d        = state_q;
        song_d         = song_q;
        reset_player_d = 1'b0;
        count_d        = count_q;
        case (state_q)
            PAUSED: begin
                if (bus.play_button) begin
                    state_d = PLAYING;
                end else if (skip) begin
                    song_d         = skip_song;
                    reset_player_d = 1'b1;
                end
            end
            PLAYING: begin
                if (bus.song_done) begin
                    reset_player_d = 1'b1;
                    if ((song_q == LAST_SONG) && !bus.loop_all) begin
                        song_d  = 2'd0;
                        state_d = PAUSED;
                    end else begin
                        song_d  = next_song;
                        count_d = GAP_LOAD;
                        state_d = GAP;
                    end
                end else if (bus.play_button) begin
                    // reader is left alone so playback resumes mid-song
                    state_d = PAUSED;
                end else if (skip) begin
                    song_d         = skip_song;
                    reset_player_d = 1'b1;
                    state_d        = SWITCH;
                end
            end
            SWITCH: begin
                // one dead cycle keeps play low while the reader resets
                state_d = PLAYING;
            end
            GAP: begin
                if (bus.play_button) begin
                    state_d = PAUSED;
                end else if (skip) begin
                    song_d         = skip_song;
                    reset_player_d = 1'b1;
                    count_d        = GAP_LOAD;
                end else if (count_q == 24'd0) begin
                    state_d = PLAYING;
                end else begin
                    count_d = count_q - 24'd1;
                end
            end
            default: begin
                state_d = PAUSED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= PAUSED;
            song_q         <= 2'd0;
            reset_player_q <= 1'b0;
            count_q        <= 24'd0;
        end else begin
            state_q        <= state_d;
            song_q         <= song_d;
            reset_player_q <= reset_player_d;
            count_q        <= count_d;
        end
    end

    assign bus.play         = (state_q == PLAYING);
    assign bus.in_gap       = (state_q == GAP);
    assign bus.song         = song_q;
    assign bus.reset_player = reset_player_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer (NUM_SONGS=4, GAP_CYCLES=4)
module tb_song_sequencer;

    typedef struct {
        logic       rst;
        logic       pb;
        logic       nb;
        logic       vb;
        logic       lp;
        logic       sd;
        logic       e_play;
        logic [1:0] e_song;
        logic       e_rp;
        logic       e_gap;
    } vec_t;

    typedef struct {
        int         idx;
        logic       play;
        logic [1:0] song;
        logic       rp;
        logic       gap;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];
    vec_t vecs[$];

    song_sequencer_if bus();

    song_sequencer #(.NUM_SONGS(4), .GAP_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic vec_t v(input logic rst, input logic pb, input logic nb, input logic vb,
                               input logic lp, input logic sd, input logic ep, input logic [1:0] es,
                               input logic er, input logic eg);
        vec_t r;
        r.rst = rst; r.pb = pb; r.nb = nb; r.vb = vb; r.lp = lp; r.sd = sd;
        r.e_play = ep; r.e_song = es; r.e_rp = er; r.e_gap = eg;
        return r;
    endfunction

    task automatic clear_inputs();
        reset = 1'b0;
        bus.play_button = 1'b0;
        bus.next_button = 1'b0;
        bus.prev_button = 1'b0;
        bus.song_done   = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   low_cnt;
        int   rp_cnt;
        n_checks = 0;
        n_pass   = 0;
        clear_inputs();
        bus.loop_all = 1'b0;

        //          rst pb nb vb lp sd | play song rp gap
        vecs.push_back(v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));  // reset
        vecs.push_back(v(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0));  // paused idle
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  1, 0, 0, 0));  // play, no reset_player
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  0, 1, 1, 0));  // next -> switch song 1
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  0, 2, 1, 1));  // done -> gap song 2
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 2, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 2, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 2, 0, 1));  // 4th gap cycle
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 2, 0, 0));  // playing again
        vecs.push_back(v(0, 0, 1, 1, 0, 0,  1, 2, 0, 0));  // next+prev ignored
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  0, 3, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  0, 0, 1, 0));  // end of list, loop off -> paused
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,  0, 3, 1, 0));  // prev wrap while paused
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  0, 3, 0, 0));  // done ignored in paused
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  1, 3, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  0, 0, 1, 0));  // next wrap while playing
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  1, 0, 0, 0));  // play ignored in switch
        vecs.push_back(v(0, 0, 0, 1, 0, 0,  0, 3, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  1, 3, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 1,  0, 0, 1, 1));  // loop_all wrap -> gap
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 1,  0, 1, 1, 1));  // done beats play
        vecs.push_back(v(0, 0, 1, 0, 0, 0,  0, 2, 1, 1));  // next in gap, reload
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  0, 2, 0, 1));  // done ignored in gap
        vecs.push_back(v(0, 1, 1, 0, 0, 0,  0, 2, 0, 0));  // play beats next in gap
        vecs.push_back(v(0, 1, 0, 0, 0, 0,  1, 2, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  0, 3, 1, 1));  // gap, count 3
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 3, 0, 1));  // count 2
        vecs.push_back(v(1, 1, 0, 0, 0, 0,  0, 0, 0, 0));  // reset mid-gap dominates
        vecs.push_back(v(0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            reset           = vecs[i].rst;
            bus.play_button = vecs[i].pb;
            bus.next_button = vecs[i].nb;
            bus.prev_button = vecs[i].vb;
            bus.loop_all    = vecs[i].lp;
            bus.song_done   = vecs[i].sd;
            e.idx  = i;
            e.play = vecs[i].e_play;
            e.song = vecs[i].e_song;
            e.rp   = vecs[i].e_rp;
            e.gap  = vecs[i].e_gap;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d play", e.idx),         int'(bus.play),         int'(e.play));
            check($sformatf("v%0d song", e.idx),         int'(bus.song),         int'(e.song));
            check($sformatf("v%0d reset_player", e.idx), int'(bus.reset_player), int'(e.rp));
            check($sformatf("v%0d in_gap", e.idx),       int'(bus.in_gap),       int'(e.gap));
        end

        // gap length measured end to end: start song 0, finish it, count dark cycles
        @(negedge clk);
        clear_inputs();
        bus.loop_all    = 1'b0;
        bus.play_button = 1'b1;
        @(negedge clk);
        bus.play_button = 1'b0;
        bus.song_done   = 1'b1;
        @(negedge clk);
        bus.song_done   = 1'b0;
        low_cnt = 0;
        rp_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.play) break;
            low_cnt++;
            rp_cnt += int'(bus.reset_player);
            @(negedge clk);
        end
        check("gap play resumes", int'(bus.play), 1);
        check("gap low cycles", low_cnt, 4);
        check("gap reset_player pulses", rp_cnt, 1);
        check("gap song", int'(bus.song), 1);

        // skip while playing: exactly one dark cycle carrying the reset pulse
        bus.next_button = 1'b1;
        @(negedge clk);
        bus.next_button = 1'b0;
        low_cnt = 0;
        rp_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.play) break;
            low_cnt++;
            rp_cnt += int'(bus.reset_player);
            @(negedge clk);
        end
        check("skip play resumes", int'(bus.play), 1);
        check("skip low cycles", low_cnt, 1);
        check("skip reset_player in low cycle", rp_cnt, 1);
        check("skip song", int'(bus.song), 2);
        check("skip reset_player cleared", int'(bus.reset_player), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
